vdp18_host_seq: RTL

- Host-side sequencer that drives the VDP CPU port (csr_n/csw_n/mode/cd) from single-word requests: register write, VRAM write, VRAM read, status read.
- Expands each request into the VDP two-byte control protocol plus data byte, with strobe width and inter-access spacing enforced.
- Sits between a system bus or soft-CPU bridge and vdp18_core. Skips address setup for sequential same-direction VRAM accesses by tracking the VDP auto-increment address.

---
 rtl/vdp18_pkg.sv | 74 +++++++
 rtl/vdp18_host_addr_track.sv | 35 +++
 rtl/vdp18_host_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vdp18_pkg.sv
// Shared types and byte-building helpers for the VDP host sequencer.
// Address/data buses are [13:0]/[7:0]: VDP bit 0 (MSB) maps to vector bit 13/7.
package vdp18_pkg;

  typedef enum logic [1:0] {
    WR_REG  = 2'd0,
    WR_VRAM = 2'd1,
    RD_VRAM = 2'd2,
    RD_STAT = 2'd3
  } host_op_t;

  typedef enum logic [2:0] {
    RESYNC,
    IDLE,
    SETUP,
    STROBE,
    GAP
  } host_state_t;

  // Byte position within an op; WR_REG uses PH_HI (data) then PH_LAST (register byte).
  typedef enum logic [1:0] {
    PH_LO   = 2'd0,
    PH_HI   = 2'd1,
    PH_LAST = 2'd2
  } host_phase_t;

  localparam logic [1:0] CB_REG   = 2'b10;
  localparam logic [1:0] CB_WADDR = 2'b01;
  localparam logic [1:0] CB_RADDR = 2'b00;

  typedef struct packed {
    logic       mode;
    logic [7:0] cd;
  } host_byte_t;

  function automatic host_byte_t host_byte(host_op_t op, host_phase_t ph, logic [13:0] addr,
                                           logic [7:0] data);
    host_byte_t b;
    b.mode = 1'b1;
    b.cd   = addr[7:0];
    if (ph == PH_HI) begin
      case (op)
        WR_REG:  b.cd = data;
        WR_VRAM: b.cd = {CB_WADDR, addr[13:8]};
        default: b.cd = {CB_RADDR, addr[13:8]};
      endcase
    end else if (ph == PH_LAST) begin
      case (op)
        WR_REG:  b.cd = {CB_REG, 3'b000, addr[2:0]};
        WR_VRAM: begin
          b.cd   = data;
          b.mode = 1'b0;
        end
        RD_VRAM: begin
          b.cd   = 8'h00;
          b.mode = 1'b0;
        end
        default: b.cd = 8'h00;
      endcase
    end
    return b;
  endfunction

  function automatic logic op_reads(host_op_t op, host_phase_t ph);
    return (ph == PH_LAST) && ((op == RD_VRAM) || (op == RD_STAT));
  endfunction

  // Long gap after VRAM data and after the read-address byte that starts a VRAM prefetch.
  function automatic logic gap_is_data(host_op_t op, host_phase_t ph);
    return ((ph == PH_LAST) && ((op == WR_VRAM) || (op == RD_VRAM))) ||
           ((ph == PH_HI) && (op == RD_VRAM));
  endfunction

endpackage

// File: rtl/vdp18_host_addr_track.sv
// Mirrors the VDP auto-increment address so sequential same-direction
// VRAM accesses can skip the two-byte address setup.
module vdp18_host_addr_track (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] chk_addr,
  input  logic        chk_rd,
  output logic        setup_req,
  input  logic        upd,
  input  logic [13:0] upd_addr,
  input  logic        upd_rd,
  input  logic        inval
);

  logic        valid_q;
  logic        rd_q;
  logic [13:0] addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
    end else if (upd) begin
      valid_q <= 1'b1;
      rd_q    <= upd_rd;
      addr_q  <= upd_addr + 14'd1;
    end else if (inval) begin
      valid_q <= 1'b0;
    end
  end

  assign setup_req = !valid_q || (rd_q != chk_rd) || (addr_q != chk_addr);

endmodule

// File: rtl/vdp18_host_seq.sv
// Host-side sequencer: expands single-word requests into VDP CPU-port
// strobes with enforced strobe width and inter-access spacing.
module vdp18_host_seq
  import vdp18_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES   = 3,
  parameter int unsigned CTRL_GAP_CYCLES = 2,
  parameter int unsigned DATA_GAP_CYCLES = 48
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [13:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        csr_n_o,
  output logic        csw_n_o,
  output logic        mode_o,
  output logic [7:0]  cd_o,
  input  logic [7:0]  cd_i
);

  localparam logic [7:0] StrobeLd  = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] CtrlGapLd = 8'(CTRL_GAP_CYCLES - 1);
  localparam logic [7:0] DataGapLd = 8'(DATA_GAP_CYCLES - 1);

  host_state_t state_q, state_d;
  host_op_t    op_q, op_d;
  host_phase_t ph_q, ph_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        resync_q, resync_d;
  logic        csr_n_q, csr_n_d, csw_n_q, csw_n_d, mode_q, mode_d;
  logic [7:0]  cd_q, cd_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        setup_req, trk_upd, trk_inval;
  host_byte_t  nb;

  vdp18_host_addr_track u_track (
    .clk       (clk_i),
    .rst       (reset_i),
    .chk_addr  (req_addr_i),
    .chk_rd    (req_op_i == RD_VRAM),
    .setup_req (setup_req),
    .upd       (trk_upd),
    .upd_addr  (addr_q),
    .upd_rd    (op_q == RD_VRAM),
    .inval     (trk_inval)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ph_d        = ph_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    resync_d    = resync_q;
    csr_n_d     = csr_n_q;
    csw_n_d     = csw_n_q;
    mode_d      = mode_q;
    cd_d        = cd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    trk_upd     = 1'b0;
    trk_inval   = 1'b0;

    case (state_q)
      RESYNC: begin
        // Dummy status read clears the VDP's first/second-byte toggle.
        op_d     = RD_STAT;
        ph_d     = PH_LAST;
        resync_d = 1'b1;
        state_d  = SETUP;
      end
      IDLE: begin
        if (req_valid_i) begin
          op_d    = host_op_t'(req_op_i);
          addr_d  = req_addr_i;
          data_d  = req_data_i;
          state_d = SETUP;
          case (op_d)
            WR_REG: begin
              ph_d      = PH_HI;
              trk_inval = 1'b1;
            end
            WR_VRAM, RD_VRAM: ph_d = setup_req ? PH_LO : PH_LAST;
            default:          ph_d = PH_LAST;
          endcase
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = StrobeLd;
        csr_n_d = !op_reads(op_q, ph_q);
        csw_n_d = op_reads(op_q, ph_q);
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          csr_n_d = 1'b1;
          csw_n_d = 1'b1;
          cnt_d   = gap_is_data(op_q, ph_q) ? DataGapLd : CtrlGapLd;
          if (op_reads(op_q, ph_q) && !resync_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = cd_i;
          end
          trk_upd = (ph_q == PH_LAST) && ((op_q == WR_VRAM) || (op_q == RD_VRAM));
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          if (ph_q == PH_LAST) begin
            state_d  = IDLE;
            resync_d = 1'b0;
          end else begin
            ph_d    = host_phase_t'(ph_q + 2'd1);
            state_d = SETUP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = RESYNC;
    endcase

    // cd/mode only change while entering SETUP, so they never move with a strobe edge.
    nb = host_byte(op_d, ph_d, addr_d, data_d);
    if ((state_d == SETUP) && (state_q != SETUP)) begin
      cd_d   = nb.cd;
      mode_d = nb.mode;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= RESYNC;
      op_q        <= WR_REG;
      ph_q        <= PH_LO;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      resync_q    <= 1'b0;
      csr_n_q     <= 1'b1;
      csw_n_q     <= 1'b1;
      mode_q      <= 1'b0;
      cd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ph_q        <= ph_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      resync_q    <= resync_d;
      csr_n_q     <= csr_n_d;
      csw_n_q     <= csw_n_d;
      mode_q      <= mode_d;
      cd_q        <= cd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign csr_n_o     = csr_n_q;
  assign csw_n_o     = csw_n_q;
  assign mode_o      = mode_q;
  assign cd_o        = cd_q;

endmodule
